muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller that executes MIPS MULT/MULTU/DIV/DIVU by sequencing the shared EXE-stage ALU one add/subtract per cycle.
- Holds the HI/LO result registers and raises busy so the hazard unit stalls later HI/LO consumers.
- Sits beside the ALU in EXE and drives the ALU operand/op mux whenever busy=1.
- ALU opcodes are the `NO_OP`, `ALU_ADD` and `ALU_SUB` macros from defines.v.

Parameters:
- W, default `WORDLENGTH (32): operand width and iteration count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  W  multiplicand / dividend
- b  in  W  multiplier / divisor
- flush  in  1  pipeline flush; aborts the operation in flight
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; hi/lo now hold the new result
- hi  out  W  product[2W-1:W] / remainder
- lo  out  W  product[W-1:0] / quotient
- alu_in1  out  W  ALU operand 1
- alu_in2  out  W  ALU operand 2
- alu_shamt  out  `SHAMT_LENGTH  tied to 0
- alu_op  out  4  ALU opcode
- alu_out  in  W  ALU result, combinational in the same cycle

Behaviour:
Reset (rst=1 at a clk edge):
- state=IDLE; busy=0, done=0, hi=0, lo=0, alu_op=`NO_OP`, alu_in1=0, alu_in2=0.
- rst overrides start and flush, including in the middle of an operation.

States:
- IDLE -> ITER on start & ~flush.
- ITER holds for W cycles, count 0..W-1, then -> FIX.
- FIX lasts 1 cycle -> DONE.
- DONE lasts 1 cycle, asserts done, then -> IDLE, or -> ITER if start is high that cycle.
- busy=1 in ITER and FIX only.

Timing:
- start sampled at edge T -> busy from T+1 through T+W+1.
- done=1 and hi/lo valid at cycle T+W+2, which is 34 cycles for W=32.
- start while busy=1 is ignored, with no queuing.
- start is accepted during the DONE cycle, giving back-to-back operation.

Operand capture on start:
- Latch op, sign flags sa=a[W-1] and sb=b[W-1].
- Signed ops latch magnitudes |a|, |b|; unsigned ops latch raw values.
- Negation of a magnitude is internal two's complement (-2^31 stays 0x80000000 and is treated as unsigned 2^31).

Multiply (shift-add, accumulator {acc_hi, mplr}):
- Each ITER cycle: alu_op=`ALU_ADD`, alu_in1=acc_hi, alu_in2=mcand.
- carry = (alu_out < acc_hi) unsigned.
- If mplr[0]: {acc_hi, mplr} <= {carry, alu_out, mplr[W-1:1]}.
- Else: {acc_hi, mplr} <= {1'b0, acc_hi, mplr[W-1:1]}.

Divide (restoring, remainder rem, quotient q; load rem=0, q=dividend magnitude):
- Each ITER cycle, form s = {rem[W-2:0], q[W-1]} with shifted-out bit t = rem[W-1].
- Drive alu_op=`ALU_SUB`, alu_in1=s, alu_in2=divisor.
- If t | (s >= divisor): rem <= alu_out and shift 1 into q.
- Else: rem <= s and shift 0 into q.

FIX cycle:
- alu_op=`NO_OP`.
- MULT: negate the 2W product if sa^sb.
- DIV: negate the quotient if sa^sb; negate the remainder if sa.
- Write hi/lo at the end of FIX.

Divide by zero:
- Runs the full latency, no exception.
- Result: lo = all ones, hi = original a (the raw value, not its magnitude) for both DIV and DIVU.

Overflow case:
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.

ALU outputs and flush:
- In IDLE/DONE: alu_op=`NO_OP`, alu_in1=alu_in2=0.
- flush in ITER or FIX: next state IDLE, busy=0, no done pulse, hi/lo keep their previous values.
- flush in IDLE blocks a same-cycle start.

Test Plan:
- Reset mid-ITER (cycle 10) -> next cycle busy=0, done=0, hi=lo=0, alu_op=`NO_OP`.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at T+34, hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; then DIV a=-7 b=2 started on the done cycle -> lo=0xFFFFFFFD hi=0xFFFFFFFF, done 34 cycles later.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- Preload hi/lo via MULTU 5*6 (lo=30); start DIVU 9/2, flush at ITER cycle 12 -> no done, hi=0 lo=30 retained; new DIVU 9/2 -> lo=4 hi=1.
- start pulsed at busy cycles 1, 15 and 33 of a MULTU 2*3 -> ignored, single done with lo=6; alu_op=`ALU_ADD` on all 32 ITER cycles.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs MULT/MULTU/DIV/DIVU on the shared EXE ALU, one add/sub per cycle.
// Latency: start at edge T -> busy T+1..T+W+1, done pulse with hi/lo valid at T+W+2.
// Backpressure: none; start is ignored while busy, flush aborts without touching hi/lo.
// Ports: clk/rst (sync, active high); start/op/a/b request; flush abort;
//   busy/done status; hi/lo result registers; alu_in1/alu_in2/alu_shamt/alu_op drive the
//   ALU operand/op mux while busy; alu_out is the ALU result in the same cycle.

`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif
`ifndef SHAMT_LENGTH
`define SHAMT_LENGTH 5
`endif
`ifndef NO_OP
`define NO_OP 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif

module muldiv_sequencer #(
  parameter int W = `WORDLENGTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  input  logic                     flush,
  output logic                     busy,
  output logic                     done,
  output logic [W-1:0]             hi,
  output logic [W-1:0]             lo,
  output logic [W-1:0]             alu_in1,
  output logic [W-1:0]             alu_in2,
  output logic [`SHAMT_LENGTH-1:0] alu_shamt,
  output logic [3:0]               alu_op,
  input  logic [W-1:0]             alu_out
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  logic          sa_q, sa_d, sb_q, sb_d;
  logic [W-1:0]  acc_q, acc_d;    // multiply: acc_hi, divide: remainder
  logic [W-1:0]  wrk_q, wrk_d;    // multiply: multiplier, divide: quotient
  logic [W-1:0]  opnd_q, opnd_d;  // multiply: multiplicand, divide: divisor
  logic [W-1:0]  araw_q, araw_d;  // raw dividend, returned in hi on divide by zero
  logic [W-1:0]  hi_q, hi_d, lo_q, lo_d;

  logic          accept;
  logic [W-1:0]  div_s;
  logic          sgn, sa_in, sb_in;
  logic [W-1:0]  amag, bmag;
  logic          carry;
  logic [2*W-1:0] prod;

  // Start is honoured from IDLE and from DONE (back-to-back), never while busy.
  assign accept = (state_q == S_IDLE || state_q == S_DONE) && start && !flush;

  // Restoring-divide shift: top bit of rem falls out as the implicit 2^W term.
  assign div_s = {acc_q[W-2:0], wrk_q[W-1]};

  assign sgn   = ~op[0];
  assign sa_in = sgn & a[W-1];
  assign sb_in = sgn & b[W-1];
  assign amag  = sa_in ? ({W{1'b0}} - a) : a;
  assign bmag  = sb_in ? ({W{1'b0}} - b) : b;
  assign carry = (alu_out < acc_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      acc_q    <= '0;
      wrk_q    <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      acc_q    <= acc_d;
      wrk_q    <= wrk_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ITER;
      S_ITER: begin
        if (flush)                         state_d = S_IDLE;
        else if (cnt_q == CW'(W - 1))      state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = accept ? S_ITER : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status and ALU mux
  always_comb begin
    busy      = (state_q == S_ITER) || (state_q == S_FIX);
    done      = (state_q == S_DONE);
    hi        = hi_q;
    lo        = lo_q;
    alu_shamt = '0;
    alu_op    = `NO_OP;
    alu_in1   = '0;
    alu_in2   = '0;
    if (state_q == S_ITER) begin
      alu_op  = is_div_q ? `ALU_SUB : `ALU_ADD;
      alu_in1 = is_div_q ? div_s : acc_q;
      alu_in2 = opnd_q;
    end
  end

  // Datapath next values
  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_d    = acc_q;
    wrk_d    = wrk_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = {acc_q, wrk_q};
    if (accept) begin
      cnt_d    = '0;
      is_div_d = op[1];
      sa_d     = sa_in;
      sb_d     = sb_in;
      acc_d    = '0;
      wrk_d    = op[1] ? amag : bmag;
      opnd_d   = op[1] ? bmag : amag;
      araw_d   = a;
    end else if (state_q == S_ITER) begin
      cnt_d = cnt_q + CW'(1);
      if (!is_div_q) begin
        // Carry out of acc_hi + mcand becomes the new top bit after the shift.
        if (wrk_q[0]) {acc_d, wrk_d} = {carry, alu_out, wrk_q[W-1:1]};
        else          {acc_d, wrk_d} = {1'b0, acc_q, wrk_q[W-1:1]};
      end else begin
        if (acc_q[W-1] || (div_s >= opnd_q)) begin
          acc_d = alu_out;
          wrk_d = {wrk_q[W-2:0], 1'b1};
        end else begin
          acc_d = div_s;
          wrk_d = {wrk_q[W-2:0], 1'b0};
        end
      end
    end else if (state_q == S_FIX && !flush) begin
      if (!is_div_q) begin
        if (sa_q ^ sb_q) prod = {(2*W){1'b0}} - {acc_q, wrk_q};
        hi_d = prod[2*W-1:W];
        lo_d = prod[W-1:0];
      end else if (opnd_q == '0) begin
        lo_d = '1;
        hi_d = araw_q;
      end else begin
        lo_d = (sa_q ^ sb_q) ? ({W{1'b0}} - wrk_q) : wrk_q;
        hi_d = sa_q ? ({W{1'b0}} - acc_q) : acc_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps

`ifndef WORDLENGTH
`define WORDLENGTH 32
`endif
`ifndef SHAMT_LENGTH
`define SHAMT_LENGTH 5
`endif
`ifndef NO_OP
`define NO_OP 4'b0000
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif

module tb_muldiv_sequencer;
  localparam int W = 32;

  logic                     clk = 1'b0;
  logic                     rst, start, flush;
  logic [1:0]               op;
  logic [W-1:0]             a, b;
  logic                     busy, done;
  logic [W-1:0]             hi, lo, alu_in1, alu_in2, alu_out;
  logic [`SHAMT_LENGTH-1:0] alu_shamt;
  logic [3:0]               alu_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Reference ALU
  assign alu_out = (alu_op == `ALU_ADD) ? alu_in1 + alu_in2 :
                   (alu_op == `ALU_SUB) ? alu_in1 - alu_in2 : '0;

  muldiv_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt),
    .alu_op(alu_op), .alu_out(alu_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, return ticks from the start edge to the done cycle and busy cycles seen.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output int busyc);
    op = o; a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    busyc = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) busyc++;
    end
  endtask

  int lat, bc, nd, bk, addc;
  logic [W-1:0] lo_seen;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_aluop", alu_op, `NO_OP);
    chk("rst_in1", alu_in1, 0);
    chk("rst_shamt", alu_shamt, 0);

    // Reset in the middle of ITER
    op = 2'b01; a = 32'd5; b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("mid_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_hi", hi, 0);
    chk("mid_lo", lo, 0);
    chk("mid_aluop", alu_op, `NO_OP);

    // MULTU max * max
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("multu_lat", lat, 34);
    chk("multu_busy", bc, 33);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    tick();
    chk("done_one_cycle", done, 0);

    // MULT -3*7, then DIV -7/2 launched from the done cycle
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, lat, bc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("div_b2b_lat", lat, 34);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    // Divide by zero and signed overflow
    run_op(2'b11, 32'd100, 32'd0, lat, bc);
    chk("divu0_lat", lat, 34);
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'h00000064);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    // Preload, then flush a divide mid-flight
    run_op(2'b01, 32'd5, 32'd6, lat, bc);
    chk("pre_lo", lo, 32'd30);
    tick();
    op = 2'b11; a = 32'd9; b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("divu_aluop", alu_op, `ALU_SUB);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    nd = 0;
    repeat (40) begin
      tick();
      if (done) nd++;
    end
    chk("flush_nodone", nd, 0);
    chk("flush_hi", hi, 0);
    chk("flush_lo", lo, 32'd30);

    // Flush in IDLE blocks start
    start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);

    run_op(2'b11, 32'd9, 32'd2, lat, bc);
    chk("divu_lo", lo, 32'd4);
    chk("divu_hi", hi, 32'd1);
    tick();

    // Starts while busy are ignored
    op = 2'b01; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    bk = 0; addc = 0; nd = 0; lo_seen = '0;
    for (int i = 0; i < 60; i++) begin
      if (busy) begin
        bk++;
        if (bk <= 32 && alu_op == `ALU_ADD) addc++;
      end
      if (done) begin
        nd++;
        lo_seen = lo;
      end
      start = busy && (bk == 1 || bk == 15 || bk == 33);
      tick();
    end
    start = 1'b0;
    chk("ign_busy_cycles", bk, 33);
    chk("ign_add_cycles", addc, 32);
    chk("ign_done_count", nd, 1);
    chk("ign_lo", lo_seen, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
